// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer
//
// Front-end control unit for an external ALU. It takes one 16-bit
// instruction at a time over a valid/ready handshake and reads both
// operands from an external register file. It then holds the ALU control
// code and operands steady for one execute cycle, captures what the ALU
// produces, and issues a single-cycle register writeback strobe.
// A skip-type op whose ALU skip output is set squashes the next
// accepted instruction.
//
// Instruction format: [15:12] op, [11:8] rd, [7:4] ra, [3:0] rb / imm4.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   instr, instr_valid    instruction offered by the fetch side
//   instr_ready           high only while idle; transfer = valid && ready
//   rf_addr_a/b           register file read addresses (ra, rb)
//   rf_data_a/b           combinational register file read data
//   alu_operand_A/B       registered ALU operands
//   alu_control           registered ALU op code (14 = ALU holds state)
//   alu_result            ALU result
//   alu_compare_flags     ALU {gt, lt, eq}
//   alu_zero, alu_skip    ALU zero indicator and should-skip output
//   wb_en/wb_addr/wb_data one-cycle register writeback
//   cmp_flags_q           flags from the most recent compare (op 11)
//   zero_q                zero indicator from the most recent writeback op
//   skip_pending          the next accepted instruction will be discarded
//   illegal_op            one-cycle pulse after op 15 is accepted

module alu_issue_sequencer #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [RADDR_W-1:0] rf_addr_a,
    output logic [RADDR_W-1:0] rf_addr_b,
    input  logic [DATA_W-1:0]  rf_data_a,
    input  logic [DATA_W-1:0]  rf_data_b,
    output logic [DATA_W-1:0]  alu_operand_A,
    output logic [DATA_W-1:0]  alu_operand_B,
    output logic [3:0]         alu_control,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic [2:0]         alu_compare_flags,
    input  logic               alu_zero,
    input  logic               alu_skip,
    output logic               wb_en,
    output logic [RADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]  wb_data,
    output logic [2:0]         cmp_flags_q,
    output logic               zero_q,
    output logic               skip_pending,
    output logic               illegal_op
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    localparam logic [3:0] OP_CMP     = 4'd11;
    localparam logic [3:0] OP_NOP     = 4'd14;
    localparam logic [3:0] OP_ILLEGAL = 4'd15;

    state_t      state;
    logic [15:0] instr_q;

    logic [3:0]  op_q;
    assign op_q = instr_q[15:12];

    // Ops whose result goes back to the register file.
    function automatic logic is_wb_op(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
    endfunction

    // Ops whose ALU skip output is meaningful.
    function automatic logic is_skip_op(input logic [3:0] op);
        return op inside {4'd3, 4'd4, 4'd12, 4'd13};
    endfunction

    // Read addresses come straight from the latched instruction; they only
    // matter during READ, when the operands are registered.
    assign rf_addr_a = RADDR_W'(instr_q[7:4]);
    assign rf_addr_b = RADDR_W'(instr_q[3:0]);

    // Sequencer FSM. Every output is registered here. A squashed, illegal or
    // NOP instruction is consumed in IDLE without touching the ALU, so
    // instr_ready stays high for those.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            instr_q       <= '0;
            instr_ready   <= 1'b1;
            alu_operand_A <= '0;
            alu_operand_B <= '0;
            alu_control   <= OP_NOP;
            wb_en         <= 1'b0;
            wb_addr       <= '0;
            wb_data       <= '0;
            cmp_flags_q   <= '0;
            zero_q        <= 1'b0;
            skip_pending  <= 1'b0;
            illegal_op    <= 1'b0;
        end else begin
            wb_en      <= 1'b0;
            illegal_op <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        if (skip_pending) begin
                            skip_pending <= 1'b0;
                        end else if (instr[15:12] == OP_ILLEGAL) begin
                            illegal_op <= 1'b1;
                        end else if (instr[15:12] != OP_NOP) begin
                            instr_q     <= instr;
                            instr_ready <= 1'b0;
                            state       <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    alu_operand_A <= rf_data_a;
                    if (op_q inside {4'd2, 4'd5, 4'd6})
                        alu_operand_B <= {{(DATA_W-4){1'b0}}, instr_q[3:0]};
                    else if (op_q inside {4'd10, 4'd12, 4'd13})
                        alu_operand_B <= '0;
                    else
                        alu_operand_B <= rf_data_b;
                    alu_control <= op_q;
                    state       <= S_EXEC;
                end
                S_EXEC: begin
                    // alu_skip is stale for non-skip ops and must not be used.
                    if (is_wb_op(op_q)) begin
                        wb_data <= alu_result;
                        zero_q  <= alu_zero;
                        wb_en   <= 1'b1;
                        wb_addr <= RADDR_W'(instr_q[11:8]);
                    end else if (op_q == OP_CMP) begin
                        cmp_flags_q <= alu_compare_flags;
                    end else if (is_skip_op(op_q)) begin
                        skip_pending <= alu_skip;
                    end
                    state <= S_WB;
                end
                S_WB: begin
                    alu_control <= OP_NOP;
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Self-checking bench for alu_issue_sequencer. It provides a behavioural
// register file and ALU. A table of instructions with hand-computed
// results is applied, and a few hand-written sequences cover squash,
// illegal/NOP and reset during execute. Writebacks are predicted into a
// scoreboard queue and matched when wb_en is seen.

module tb_alu_issue_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  rf_addr_a, rf_addr_b;
    logic [15:0] rf_data_a, rf_data_b;
    logic [15:0] alu_operand_A, alu_operand_B;
    logic [3:0]  alu_control;
    logic [15:0] alu_result;
    logic [2:0]  alu_compare_flags;
    logic        alu_zero, alu_skip;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [2:0]  cmp_flags_q;
    logic        zero_q, skip_pending, illegal_op;

    logic [15:0] rf [16];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } wb_t;
    wb_t sb_q[$];

    typedef struct {
        logic [3:0]  op, rd, ra, rb;
        logic [15:0] a_val, b_val;
        logic        exp_wb;
        logic [15:0] exp_data;
        logic        exp_zero;
        logic [2:0]  exp_flags;
    } vec_t;

    alu_issue_sequencer #(.DATA_W(16), .RADDR_W(4)) dut (
        .clk(clk), .reset(reset),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .alu_operand_A(alu_operand_A), .alu_operand_B(alu_operand_B),
        .alu_control(alu_control), .alu_result(alu_result),
        .alu_compare_flags(alu_compare_flags), .alu_zero(alu_zero),
        .alu_skip(alu_skip),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .cmp_flags_q(cmp_flags_q), .zero_q(zero_q),
        .skip_pending(skip_pending), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    assign rf_data_a = rf[rf_addr_a];
    assign rf_data_b = rf[rf_addr_b];

    // Behavioural ALU: 0 add, 1 sub, 2 (A+B)<<12, 5 sub, 6 shl, 7 and,
    // 8 or, 9 xor, 10 add, 11 compare; skip ops 3 (A==B), 4 (A!=B),
    // 12 (A==0), 13 (A!=0).
    always_comb begin
        alu_result = '0;
        alu_skip   = 1'b0;
        case (alu_control)
            4'd0:  alu_result = alu_operand_A + alu_operand_B;
            4'd1:  alu_result = alu_operand_A - alu_operand_B;
            4'd2:  alu_result = (alu_operand_A + alu_operand_B) << 12;
            4'd3:  alu_skip   = (alu_operand_A == alu_operand_B);
            4'd4:  alu_skip   = (alu_operand_A != alu_operand_B);
            4'd5:  alu_result = alu_operand_A - alu_operand_B;
            4'd6:  alu_result = alu_operand_A << alu_operand_B[3:0];
            4'd7:  alu_result = alu_operand_A & alu_operand_B;
            4'd8:  alu_result = alu_operand_A | alu_operand_B;
            4'd9:  alu_result = alu_operand_A ^ alu_operand_B;
            4'd10: alu_result = alu_operand_A + alu_operand_B;
            4'd12: alu_skip   = (alu_operand_A == 16'd0);
            4'd13: alu_skip   = (alu_operand_A != 16'd0);
            default: alu_result = '0;
        endcase
        alu_zero          = (alu_result == 16'd0);
        alu_compare_flags = {alu_operand_A > alu_operand_B,
                             alu_operand_A < alu_operand_B,
                             alu_operand_A == alu_operand_B};
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", name, actual, expected);
        end
    endtask

    // Advance to the next falling edge and match any writeback there
    // against the scoreboard.
    task automatic tick();
        wb_t exp;
        @(negedge clk);
        if (wb_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_wb: got addr %0d data 0x%04h expected no writeback",
                         wb_addr, wb_data);
            end else begin
                exp = sb_q.pop_front();
                checkOutput("wb_addr", 16'(wb_addr), 16'(exp.addr));
                checkOutput("wb_data", wb_data, exp.data);
            end
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ready"},   16'(instr_ready), 16'd1);
        checkOutput({tag, "_wb_en"},   16'(wb_en), 16'd0);
        checkOutput({tag, "_illegal"}, 16'(illegal_op), 16'd0);
        checkOutput({tag, "_flags"},   16'(cmp_flags_q), 16'd0);
        checkOutput({tag, "_zero"},    16'(zero_q), 16'd0);
        checkOutput({tag, "_skip"},    16'(skip_pending), 16'd0);
        checkOutput({tag, "_ctrl"},    16'(alu_control), 16'd14);
        checkOutput({tag, "_opA"},     alu_operand_A, 16'd0);
        checkOutput({tag, "_opB"},     alu_operand_B, 16'd0);
        checkOutput({tag, "_wb_addr"}, 16'(wb_addr), 16'd0);
        checkOutput({tag, "_wb_data"}, wb_data, 16'd0);
    endtask

    // Offer one instruction (called just after a falling edge while idle),
    // predict its writeback, then measure how long instr_ready stays low.
    // The EXEC cycle is the second low cycle; the WB cycle is the third.
    task automatic runInstr(input string name, input logic [15:0] word,
                            input logic exp_wb, input logic [15:0] exp_data,
                            input logic [15:0] exp_a, input int exp_low);
        int low;
        wb_t e;
        checkOutput({name, "_ready_before"}, 16'(instr_ready), 16'd1);
        if (exp_wb) begin
            e.addr = word[11:8];
            e.data = exp_data;
            sb_q.push_back(e);
        end
        instr       = word;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        low = 0;
        while (instr_ready !== 1'b1 && low < 8) begin
            low++;
            if (low == 2) begin
                checkOutput({name, "_exec_ctrl"}, 16'(alu_control), 16'(word[15:12]));
                checkOutput({name, "_exec_opA"}, alu_operand_A, exp_a);
            end
            if (low == 3)
                checkOutput({name, "_wb_cycle"}, 16'(wb_en), 16'(exp_wb));
            tick();
        end
        checkOutput({name, "_ready_low_cycles"}, 16'(low), 16'(exp_low));
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        string name;
        name = $sformatf("vec%0d", idx);
        rf[v.ra] = v.a_val;
        rf[v.rb] = v.b_val;
        runInstr(name, {v.op, v.rd, v.ra, v.rb}, v.exp_wb, v.exp_data, v.a_val, 3);
        checkOutput({name, "_zero_q"}, 16'(zero_q), 16'(v.exp_zero));
        checkOutput({name, "_cmp_flags"}, 16'(cmp_flags_q), 16'(v.exp_flags));
        checkOutput({name, "_skip"}, 16'(skip_pending), 16'd0);
    endtask

    initial begin
        vec_t vecs[$];
        //            op    rd    ra    rb    A         B         wb    data      z     flags
        vecs.push_back('{4'd0,  4'd3, 4'd1, 4'd2, 16'h0005, 16'h000A, 1'b1, 16'h000F, 1'b0, 3'b000});
        vecs.push_back('{4'd1,  4'd4, 4'd1, 4'd2, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 3'b000});
        vecs.push_back('{4'd2,  4'd5, 4'd1, 4'd2, 16'h0001, 16'h7777, 1'b1, 16'h3000, 1'b0, 3'b000});
        vecs.push_back('{4'd11, 4'd6, 4'd1, 4'd2, 16'h0003, 16'h0007, 1'b0, 16'h0000, 1'b0, 3'b010});
        vecs.push_back('{4'd0,  4'd7, 4'd1, 4'd2, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 3'b010});
        vecs.push_back('{4'd7,  4'd0, 4'd1, 4'd2, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b0, 3'b010});
        vecs.push_back('{4'd8,  4'd8, 4'd1, 4'd2, 16'h00F0, 16'h0F00, 1'b1, 16'h0FF0, 1'b0, 3'b010});
        vecs.push_back('{4'd9,  4'd9, 4'd1, 4'd2, 16'hAAAA, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 3'b010});
        vecs.push_back('{4'd10, 4'hA, 4'd1, 4'd2, 16'h1234, 16'h5555, 1'b1, 16'h1234, 1'b0, 3'b010});
        vecs.push_back('{4'd5,  4'hB, 4'd1, 4'd3, 16'h0010, 16'h7777, 1'b1, 16'h000D, 1'b0, 3'b010});
        vecs.push_back('{4'd6,  4'hC, 4'd1, 4'd4, 16'h0001, 16'h7777, 1'b1, 16'h0010, 1'b0, 3'b010});
        vecs.push_back('{4'd11, 4'hD, 4'd1, 4'd2, 16'h0009, 16'h0009, 1'b0, 16'h0000, 1'b0, 3'b001});
        vecs.push_back('{4'd3,  4'hE, 4'd1, 4'd2, 16'h0005, 16'h0006, 1'b0, 16'h0000, 1'b0, 3'b001});
        vecs.push_back('{4'd13, 4'hF, 4'd1, 4'd2, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 3'b001});
        vecs.push_back('{4'd4,  4'd1, 4'd1, 4'd2, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 3'b001});

        for (int i = 0; i < 16; i++) rf[i] = 16'(i);
        reset       = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;
        tick();
        tick();
        checkResetState("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i], i);

        // Skip op with A==0 arms the squash; the next ADD is swallowed in
        // IDLE, and the ADD after it writes back normally.
        rf[1] = 16'h0000;
        runInstr("skip_arm", {4'd12, 4'd1, 4'd1, 4'd2}, 1'b0, 16'h0, 16'h0000, 3);
        checkOutput("skip_armed", 16'(skip_pending), 16'd1);
        rf[1] = 16'h0001;
        rf[2] = 16'h0002;
        runInstr("squashed_add", {4'd0, 4'd3, 4'd1, 4'd2}, 1'b0, 16'h0, 16'h0, 0);
        checkOutput("skip_cleared", 16'(skip_pending), 16'd0);
        runInstr("post_squash_add", {4'd0, 4'd3, 4'd1, 4'd2}, 1'b1, 16'h0003, 16'h0001, 3);

        // Illegal op pulses illegal_op for one cycle with no ALU activity.
        runInstr("illegal", {4'd15, 4'd3, 4'd1, 4'd2}, 1'b0, 16'h0, 16'h0, 0);
        checkOutput("illegal_pulse", 16'(illegal_op), 16'd1);
        checkOutput("illegal_ctrl", 16'(alu_control), 16'd14);
        tick();
        checkOutput("illegal_pulse_end", 16'(illegal_op), 16'd0);

        // NOP is consumed in IDLE.
        runInstr("nop", {4'd14, 4'd3, 4'd1, 4'd2}, 1'b0, 16'h0, 16'h0, 0);
        checkOutput("nop_illegal", 16'(illegal_op), 16'd0);
        checkOutput("nop_ctrl", 16'(alu_control), 16'd14);

        // Reset during EXEC of an ADD: no writeback, everything back to reset.
        rf[1]       = 16'h0011;
        rf[2]       = 16'h0022;
        instr       = {4'd0, 4'd6, 4'd1, 4'd2};
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        checkOutput("rst_exec_ctrl", 16'(alu_control), 16'd0);
        reset = 1'b1;
        tick();
        checkResetState("rst_exec");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("rst_exec_ready", 16'(instr_ready), 16'd1);

        checkOutput("scoreboard_empty", 16'(sb_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
